axi_light_arbiter_2to1: RTL

Two-requester AXI-lite arbiter that shares one downstream AXI-lite port, typically the slave side of an `axi_offset_external` window, between two upstream masters. It grants one complete transaction at a time (AW+W+B or AR+R) and routes the granted slave port to the master port. It blocks the loser until the transaction's response handshake completes. Arbitration is round-robin, or fixed priority when the configuration macro is absent.

---
 rtl/axi_light_arbiter_2to1_if.sv | 45 ++++
 rtl/axi_light_arbiter_2to1.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/axi_light_arbiter_2to1_if.sv
// AXI-lite bundle shared by the 2:1 arbiter and its requesters.
// Master drives requests; slave drives readies and responses.
interface if_axi_light #(
  parameter int AXI_ADDR_WIDTH  = 32,
  parameter int AXI_DATA_WIDTH  = 32,
  parameter int AXI_WSTRB_WIDTH = 4
);
  logic                       awvalid;
  logic                       awready;
  logic [AXI_ADDR_WIDTH-1:0]  awaddr;
  logic [2:0]                 awprot;
  logic                       wvalid;
  logic                       wready;
  logic [AXI_DATA_WIDTH-1:0]  wdata;
  logic [AXI_WSTRB_WIDTH-1:0] wstrb;
  logic                       bvalid;
  logic                       bready;
  logic [1:0]                 bresp;
  logic                       arvalid;
  logic                       arready;
  logic [AXI_ADDR_WIDTH-1:0]  araddr;
  logic [2:0]                 arprot;
  logic                       rvalid;
  logic                       rready;
  logic [AXI_DATA_WIDTH-1:0]  rdata;
  logic [1:0]                 rresp;

  modport master (
    output awvalid, awaddr, awprot,
    output wvalid, wdata, wstrb,
    output bready, arvalid, araddr, arprot,
    output rready,
    input  awready, wready, bvalid, bresp,
    input  arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot,
    input  wvalid, wdata, wstrb,
    input  bready, arvalid, araddr, arprot,
    input  rready,
    output awready, wready, bvalid, bresp,
    output arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axi_light_arbiter_2to1.sv
// 2:1 AXI-lite arbiter, one whole transaction per grant.
// Define AXI_ARB_ROUND_ROBIN_EN for round-robin; else s0 has priority.
module axi_light_arbiter_2to1 #(
  parameter int WRITE_FIRST = 1
) (
  input  logic       clk,
  input  logic       res_n,
  if_axi_light.slave  s0_axi,
  if_axi_light.slave  s1_axi,
  if_axi_light.master m_axi,
  output logic [1:0] grant,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic       aw_done_q, aw_done_d;
  logic       w_done_q, w_done_d;
  logic       owner;
  logic       req0, req1, pick1;
  logic       pick_aw, pick_ar, is_wr;
  logic       aw_hs, w_hs;
`ifdef AXI_ARB_ROUND_ROBIN_EN
  logic       last_q, last_d;
`endif

  assign owner = grant_q[1];
  assign grant = grant_q;
  assign busy  = (state_q != IDLE);

  // Pick the next owner and its transaction type in IDLE.
  always_comb begin
    req0  = s0_axi.awvalid | s0_axi.arvalid;
    req1  = s1_axi.awvalid | s1_axi.arvalid;
`ifdef AXI_ARB_ROUND_ROBIN_EN
    pick1 = req1 & (~req0 | ~last_q);
`else
    pick1 = req1 & ~req0;
`endif
    pick_aw = pick1 ? s1_axi.awvalid : s0_axi.awvalid;
    pick_ar = pick1 ? s1_axi.arvalid : s0_axi.arvalid;
    is_wr   = pick_aw & (~pick_ar | (WRITE_FIRST != 0));
  end

  // Next state, grant and write-channel completion flags.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
`ifdef AXI_ARB_ROUND_ROBIN_EN
    last_d    = last_q;
`endif
    aw_hs = m_axi.awvalid & m_axi.awready;
    w_hs  = m_axi.wvalid & m_axi.wready;
    unique case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          grant_d = pick1 ? 2'b10 : 2'b01;
          state_d = is_wr ? WR_REQ : RD_REQ;
        end
      end
      WR_REQ: begin
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        if (aw_done_d & w_done_d) begin
          state_d   = WR_RESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      WR_RESP: begin
        if (m_axi.bvalid & m_axi.bready) begin
          state_d = IDLE;
          grant_d = 2'b00;
`ifdef AXI_ARB_ROUND_ROBIN_EN
          last_d  = owner;
`endif
        end
      end
      RD_REQ: begin
        if (m_axi.arvalid & m_axi.arready) begin
          state_d = RD_RESP;
        end
      end
      RD_RESP: begin
        if (m_axi.rvalid & m_axi.rready) begin
          state_d = IDLE;
          grant_d = 2'b00;
`ifdef AXI_ARB_ROUND_ROBIN_EN
          last_d  = owner;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (!res_n) begin
      state_q   <= IDLE;
      grant_q   <= 2'b00;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
`ifdef AXI_ARB_ROUND_ROBIN_EN
      last_q    <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
`ifdef AXI_ARB_ROUND_ROBIN_EN
      last_q    <= last_d;
`endif
    end
  end

  // Route the owner's channels for the current phase; all else idles at 0.
  always_comb begin
    m_axi.awvalid  = 1'b0;
    m_axi.awaddr   = '0;
    m_axi.awprot   = '0;
    m_axi.wvalid   = 1'b0;
    m_axi.wdata    = '0;
    m_axi.wstrb    = '0;
    m_axi.bready   = 1'b0;
    m_axi.arvalid  = 1'b0;
    m_axi.araddr   = '0;
    m_axi.arprot   = '0;
    m_axi.rready   = 1'b0;
    s0_axi.awready = 1'b0;
    s0_axi.wready  = 1'b0;
    s0_axi.bvalid  = 1'b0;
    s0_axi.bresp   = '0;
    s0_axi.arready = 1'b0;
    s0_axi.rvalid  = 1'b0;
    s0_axi.rdata   = '0;
    s0_axi.rresp   = '0;
    s1_axi.awready = 1'b0;
    s1_axi.wready  = 1'b0;
    s1_axi.bvalid  = 1'b0;
    s1_axi.bresp   = '0;
    s1_axi.arready = 1'b0;
    s1_axi.rvalid  = 1'b0;
    s1_axi.rdata   = '0;
    s1_axi.rresp   = '0;
    unique case (state_q)
      WR_REQ: begin
        if (owner) begin
          m_axi.awvalid  = s1_axi.awvalid & ~aw_done_q;
          m_axi.awaddr   = s1_axi.awaddr;
          m_axi.awprot   = s1_axi.awprot;
          m_axi.wvalid   = s1_axi.wvalid & ~w_done_q;
          m_axi.wdata    = s1_axi.wdata;
          m_axi.wstrb    = s1_axi.wstrb;
          s1_axi.awready = m_axi.awready & ~aw_done_q;
          s1_axi.wready  = m_axi.wready & ~w_done_q;
        end else begin
          m_axi.awvalid  = s0_axi.awvalid & ~aw_done_q;
          m_axi.awaddr   = s0_axi.awaddr;
          m_axi.awprot   = s0_axi.awprot;
          m_axi.wvalid   = s0_axi.wvalid & ~w_done_q;
          m_axi.wdata    = s0_axi.wdata;
          m_axi.wstrb    = s0_axi.wstrb;
          s0_axi.awready = m_axi.awready & ~aw_done_q;
          s0_axi.wready  = m_axi.wready & ~w_done_q;
        end
      end
      WR_RESP: begin
        if (owner) begin
          m_axi.bready  = s1_axi.bready;
          s1_axi.bvalid = m_axi.bvalid;
          s1_axi.bresp  = m_axi.bresp;
        end else begin
          m_axi.bready  = s0_axi.bready;
          s0_axi.bvalid = m_axi.bvalid;
          s0_axi.bresp  = m_axi.bresp;
        end
      end
      RD_REQ: begin
        if (owner) begin
          m_axi.arvalid  = s1_axi.arvalid;
          m_axi.araddr   = s1_axi.araddr;
          m_axi.arprot   = s1_axi.arprot;
          s1_axi.arready = m_axi.arready;
        end else begin
          m_axi.arvalid  = s0_axi.arvalid;
          m_axi.araddr   = s0_axi.araddr;
          m_axi.arprot   = s0_axi.arprot;
          s0_axi.arready = m_axi.arready;
        end
      end
      RD_RESP: begin
        if (owner) begin
          m_axi.rready  = s1_axi.rready;
          s1_axi.rvalid = m_axi.rvalid;
          s1_axi.rdata  = m_axi.rdata;
          s1_axi.rresp  = m_axi.rresp;
        end else begin
          m_axi.rready  = s0_axi.rready;
          s0_axi.rvalid = m_axi.rvalid;
          s0_axi.rdata  = m_axi.rdata;
          s0_axi.rresp  = m_axi.rresp;
        end
      end
      default: ;
    endcase
  end

endmodule
